shift_ctrl: RTL

Sequencer for the ARM7TDMI operand-2 barrel shift. Accepts decoded shift requests from the execute stage, fetches the register-specified shift amount through an extra cycle when needed, drives the combinational shift core, and applies the ARM boundary rules: #0 encodings, amounts ≥32, and RRX. Returns the result and shifter carry-out to the ALU over a valid/ready handshake.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_core.sv | 92 +++++++++
 rtl/shift_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types for the operand-2 shift sequencer: shift kinds, FSM states and datapath width.
package shift_pkg;

    localparam int unsigned SHIFT_W = 32;

    typedef enum logic [1:0] {
        ShLsl = 2'b00,
        ShLsr = 2'b01,
        ShAsr = 2'b10,
        ShRor = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StRsWait,
        StDone
    } state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM barrel shifter: applies the immediate #0 encodings, register amounts
// of 32 and above, and RRX, producing the result and the shifter carry-out.
module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] op,
    input  logic [1:0]         sh_type,
    input  logic [7:0]         amt,
    input  logic               is_imm,
    input  logic               cin,
    output logic [SHIFT_W-1:0] res,
    output logic               cout
);

    logic [4:0]         sh;
    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_w;
    logic [63:0]        ror_w;

    // The extra bit of each widened shift catches the last bit shifted out.
    always_comb begin
        sh    = amt[4:0];
        lsl_w = {1'b0, op} << sh;
        lsr_w = {op, 1'b0} >> sh;
        asr_w = $signed({op, 1'b0}) >>> sh;
        ror_w = {op, op} >> sh;
        res   = op;
        cout  = cin;

        if (is_imm && amt == 8'd0) begin
            unique case (shift_type_e'(sh_type))
                ShLsl: begin
                    res  = op;
                    cout = cin;
                end
                ShLsr: begin
                    res  = '0;
                    cout = op[31];
                end
                ShAsr: begin
                    res  = {SHIFT_W{op[31]}};
                    cout = op[31];
                end
                ShRor: begin
                    res  = {cin, op[31:1]};
                    cout = op[0];
                end
            endcase
        end else if (amt != 8'd0) begin
            unique case (shift_type_e'(sh_type))
                ShLsl: begin
                    if (amt < 8'd32) begin
                        res  = lsl_w[31:0];
                        cout = lsl_w[32];
                    end else begin
                        res  = '0;
                        cout = (amt == 8'd32) ? op[0] : 1'b0;
                    end
                end
                ShLsr: begin
                    if (amt < 8'd32) begin
                        res  = lsr_w[32:1];
                        cout = lsr_w[0];
                    end else begin
                        res  = '0;
                        cout = (amt == 8'd32) ? op[31] : 1'b0;
                    end
                end
                ShAsr: begin
                    if (amt < 8'd32) begin
                        res  = asr_w[32:1];
                        cout = asr_w[0];
                    end else begin
                        res  = {SHIFT_W{op[31]}};
                        cout = op[31];
                    end
                end
                ShRor: begin
                    if (sh == 5'd0) begin
                        res  = op;
                        cout = op[31];
                    end else begin
                        res  = ror_w[31:0];
                        cout = ror_w[31];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Operand-2 shift sequencer: accepts shift requests, fetches Rs when needed and returns the
// registered result over valid/ready. Define SHIFT_CTRL_STATS_EN for op/stall counters.
module shift_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_type,
    input  logic          req_is_reg,
    input  logic [4:0]    req_imm_amt,
    input  logic [DW-1:0] req_operand,
    input  logic          req_carry_in,
    output logic          rs_req,
    input  logic          rs_valid,
    input  logic [7:0]    rs_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_carry
`ifdef SHIFT_CTRL_STATS_EN
    ,
    output logic [31:0]   stat_ops,
    output logic [31:0]   stat_stall
`endif
);

    state_e          state_q;
    logic [DW-1:0]   op_q;
    logic [1:0]      type_q;
    logic            cin_q;
    logic            rs_req_q;
    logic            res_valid_q;
    logic [DW-1:0]   res_data_q;
    logic            res_carry_q;

    logic            in_rs;
    logic            accept;
    logic [DW-1:0]   core_op;
    logic [1:0]      core_type;
    logic [7:0]      core_amt;
    logic            core_cin;
    logic [DW-1:0]   core_res;
    logic            core_cout;

    // Immediate requests shift straight from the request bus; register requests use the
    // captured operand once Rs arrives.
    always_comb begin
        in_rs     = (state_q == StRsWait);
        core_op   = in_rs ? op_q : req_operand;
        core_type = in_rs ? type_q : req_type;
        core_amt  = in_rs ? rs_data : {3'b000, req_imm_amt};
        core_cin  = in_rs ? cin_q : req_carry_in;
        req_ready = rst_n & ((state_q == StIdle) | ((state_q == StDone) & res_ready));
        accept    = req_valid & req_ready;
    end

    shift_core u_shift_core (
        .op      (core_op),
        .sh_type (core_type),
        .amt     (core_amt),
        .is_imm  (~in_rs),
        .cin     (core_cin),
        .res     (core_res),
        .cout    (core_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            type_q      <= '0;
            cin_q       <= 1'b0;
            rs_req_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_operand;
                type_q <= req_type;
                cin_q  <= req_carry_in;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (req_is_reg) begin
                            state_q     <= StRsWait;
                            rs_req_q    <= 1'b1;
                            res_valid_q <= 1'b0;
                        end else begin
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                            res_data_q  <= core_res;
                            res_carry_q <= core_cout;
                        end
                    end else if (state_q == StDone && res_ready) begin
                        state_q     <= StIdle;
                        res_valid_q <= 1'b0;
                    end
                end
                StRsWait: begin
                    if (rs_valid) begin
                        state_q     <= StDone;
                        rs_req_q    <= 1'b0;
                        res_valid_q <= 1'b1;
                        res_data_q  <= core_res;
                        res_carry_q <= core_cout;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rs_req    = rs_req_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;

`ifdef SHIFT_CTRL_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (res_valid_q && res_ready) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if (state_q == StRsWait || (state_q == StDone && !res_ready)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
